// File: rtl/serial_out_tx.sv
// FIFO-buffered asynchronous serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define SERIAL_OUT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_out_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DATA_W       = 8
) (
    input  logic                        CLK,
    input  logic                        NCLR,
    input  logic [DATA_W-1:0]           DIN,
    input  logic                        DIN_VALID,
    output logic                        DIN_READY,
    output logic                        SERIAL_OUT,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

`ifdef SERIAL_OUT_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
`ifdef SERIAL_OUT_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              push;
    logic              pop;
    logic              load;
    logic              bit_end;
    logic [DATA_W-1:0] head;

    always_comb begin
        DIN_READY  = (count_q < CntFull);
        SERIAL_OUT = serial_q;
        BUSY       = busy_q;
        FIFO_COUNT = count_q;
    end

    assign push    = DIN_VALID && DIN_READY;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (baud_q == BaudLast);

    // Serial level is computed for the state being entered so the line flop tracks the FSM.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
`ifdef SERIAL_OUT_PARITY_EN
        parity_d = parity_q;
`endif
        load     = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                if (count_q != '0) begin
                    load = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = StData;
                    serial_d = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BitLast) begin
`ifdef SERIAL_OUT_PARITY_EN
                        state_d  = StParity;
                        serial_d = parity_q;
`else
                        state_d  = StStop;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        serial_d = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef SERIAL_OUT_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    baud_d   = '0;
                    state_d  = StStop;
                    serial_d = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d  = StIdle;
                        serial_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                serial_d = 1'b1;
            end
        endcase

        // Back-to-back frames: a pop from STOP goes straight to START with no idle bit.
        if (load) begin
            pop      = 1'b1;
            shift_d  = head;
            baud_d   = '0;
            state_d  = StStart;
            serial_d = 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            parity_d = ^head;
`endif
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        busy_d = (state_d != StIdle) || (count_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge NCLR) begin
        if (!NCLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
`ifdef SERIAL_OUT_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
